// File: rtl/bcd_seq_convert.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// One shift per clock through a shared per-digit add-3 datapath.
module bcd_seq_convert #(
  parameter int W      = 8,
  parameter int DIGITS = 3,
  parameter int CW     = $clog2(W + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t          state_q;
  logic [W-1:0]    sh_q;
  logic [BW-1:0]   acc_q;
  logic [BW-1:0]   bcd_q;
  logic [CW-1:0]   cnt_q;
  logic            sticky_q;
  logic            busy_q;
  logic            done_q;
  logic            ovf_q;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   acc_d;
  logic            sticky_d;

  // Correct every digit before the shift; carry out of a digit is dropped.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_d    = {adj[BW-2:0], sh_q[W-1]};
    sticky_d = sticky_q | adj[BW-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      acc_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sh_q     <= bin;
            acc_q    <= '0;
            cnt_q    <= CW'(W);
            sticky_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= CONV;
          end
        end
        CONV: begin
          sh_q     <= {sh_q[W-2:0], 1'b0};
          acc_q    <= acc_d;
          sticky_q <= sticky_d;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
            if (sticky_d) begin
              bcd_q <= {DIGITS{4'h9}};
              ovf_q <= 1'b1;
            end else begin
              bcd_q <= acc_d;
              ovf_q <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_seq_convert.sv
// Directed bench for bcd_seq_convert in three W/DIGITS configurations.
// Expected values are hand-computed or derived by decimal division.
module tb_bcd_seq_convert;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, start4 = 1'b0, start82 = 1'b0;
  logic [7:0]  bin8 = '0, bin82 = '0;
  logic [3:0]  bin4 = '0;
  logic        busy8, done8, ovf8;
  logic        busy4, done4, ovf4;
  logic        busy82, done82, ovf82;
  logic [11:0] bcd8;
  logic [7:0]  bcd4, bcd82;

  int          checks = 0;
  int          errors = 0;
  int          sel = 0;
  logic        busy_m, done_m, ovf_m;
  logic [11:0] bcd_m;

  always #5 clk = ~clk;

  bcd_seq_convert #(.W(8), .DIGITS(3)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8)
  );

  bcd_seq_convert #(.W(4), .DIGITS(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bin(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
  );

  bcd_seq_convert #(.W(8), .DIGITS(2)) u82 (
    .clk(clk), .rst_n(rst_n), .start(start82), .bin(bin82),
    .busy(busy82), .done(done82), .bcd(bcd82), .ovf(ovf82)
  );

  always_comb begin
    busy_m = busy8;
    done_m = done8;
    ovf_m  = ovf8;
    bcd_m  = bcd8;
    if (sel == 1) begin
      busy_m = busy4;
      done_m = done4;
      ovf_m  = ovf4;
      bcd_m  = {4'h0, bcd4};
    end else if (sel == 2) begin
      busy_m = busy82;
      done_m = done82;
      ovf_m  = ovf82;
      bcd_m  = {4'h0, bcd82};
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d2, d1, d0};
  endfunction

  function automatic int val5(input int c);
    return (c * 37 + 5) % 256;
  endfunction

  // Pulse start on the selected DUT, then check latency, busy span and result.
  task automatic run(input int s, input logic [7:0] b,
                     input logic [11:0] eb, input logic eo,
                     input string tag);
    int n;
    int nb;
    int w;
    w   = (s == 1) ? 4 : 8;
    sel = s;
    if (s == 0) begin start8 = 1'b1; bin8 = b; end
    if (s == 1) begin start4 = 1'b1; bin4 = b[3:0]; end
    if (s == 2) begin start82 = 1'b1; bin82 = b; end
    @(posedge clk); #1;
    start8 = 1'b0; start4 = 1'b0; start82 = 1'b0;
    bin8 = 8'hA5; bin4 = 4'h7; bin82 = 8'h5A;
    n  = 0;
    nb = 0;
    while (!done_m && n < 40) begin
      if (busy_m) nb++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, w);
    check({tag, " busy_cycles"}, nb, w);
    check({tag, " busy_in_done"}, busy_m, 0);
    check({tag, " bcd"}, bcd_m, eb);
    check({tag, " ovf"}, ovf_m, eo);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, done_m, 0);
    check({tag, " bcd_held"}, bcd_m, eb);
  endtask

  initial begin
    int seen;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst bcd", bcd8, 0);
    check("rst ovf", ovf8, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // W=8 DIGITS=3
    run(0, 8'd0, 12'h000, 1'b0, "w8 zero");
    run(0, 8'd255, 12'h255, 1'b0, "w8 255");
    run(0, 8'd99, 12'h099, 1'b0, "w8 99");
    run(0, 8'd128, 12'h128, 1'b0, "w8 128");
    repeat (3) @(posedge clk);
    #1;
    check("w8 idle hold", bcd8, 12'h128);

    // W=4 DIGITS=2 sweep
    for (int i = 0; i < 16; i++)
      run(1, 8'(i), to_bcd(i), 1'b0, $sformatf("w4 %0d", i));

    // W=8 DIGITS=2 overflow
    run(2, 8'd100, 12'h099, 1'b1, "w8d2 100");
    run(2, 8'd99, 12'h099, 1'b0, "w8d2 99");
    run(2, 8'd255, 12'h099, 1'b1, "w8d2 255");

    // start held high, bin changing every cycle
    sel    = 0;
    start8 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bin8 = 8'(val5(c));
      @(posedge clk); #1;
      if (c % 10 == 8) begin
        check($sformatf("held done c%0d", c), done8, 1);
        check($sformatf("held bcd c%0d", c), bcd8, to_bcd(val5(c - 8)));
      end else begin
        check($sformatf("held nodone c%0d", c), done8, 0);
      end
      if (c % 10 == 9)
        check($sformatf("held no_accept c%0d", c), busy8, 0);
      if (c % 10 == 0)
        check($sformatf("held accept c%0d", c), busy8, 1);
    end
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset at the third CONV edge of a 200 conversion
    start8 = 1'b1;
    bin8   = 8'd200;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort bcd", bcd8, 0);
    check("abort ovf", ovf8, 0);
    rst_n = 1'b1;
    seen  = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    check("abort no_done", seen, 0);
    run(0, 8'd37, 12'h037, 1'b0, "w8 37");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_seq_convert.md
Name: bcd_seq_convert

Overview:
- Sequential binary-to-BCD converter controller using the shift-and-add-3 (double-dabble) method.
- Accepts a W-bit binary word on a start pulse and runs one shift per clock.
- Returns a DIGITS-digit packed BCD result with a one-cycle done pulse.
- Replaces wide combinational converters where W > 4; shares one small add-3 datapath across all iterations.

Parameters:
- W, 8, binary input width (W >= 2).
- DIGITS, 3, number of BCD output digits; result width is 4*DIGITS.
- CW, $clog2(W+1), iteration counter width (derived; do not override).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request conversion; sampled only in IDLE.
- bin, input, W, binary operand; sampled on the accepting edge only.
- busy, output, 1, high while a conversion is in progress (CONV state).
- done, output, 1, one-cycle pulse; bcd/ovf are valid in this cycle.
- bcd, output, 4*DIGITS, packed BCD result; digit 0 is in bits [3:0]; held until the next accept or reset.
- ovf, output, 1, result does not fit in DIGITS digits; held with bcd.

Behaviour:
- Reset: sampled at a clk edge with rst_n low.
  - state -> IDLE; busy=0, done=0, bcd=0, ovf=0.
  - Internal shift register, accumulator, counter and sticky overflow are cleared.
  - Reset overrides all other inputs on that edge.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at edge k: bin is loaded into the shift register, the accumulator is cleared to 0, the counter is set to W, and the overflow flag is cleared. Next state is CONV.
  - bcd and ovf keep their previous values until the result update.
- CONV: one iteration per edge, edges k+1 .. k+W.
  - (a) Each 4-bit accumulator digit >= 5 gets +3. Digits are corrected in parallel, and the carry of the add is discarded within the digit.
  - (b) The {accumulator, shift register} concatenation shifts left by 1. The shift register MSB enters accumulator bit 0.
  - (c) If the bit leaving accumulator bit 4*DIGITS-1 is 1, the sticky overflow flag is set.
  - (d) The counter decrements.
  - On the edge where the counter goes 1 -> 0 (edge k+W):
    - If overflow is clear, bcd <= the corrected-and-shifted accumulator value and ovf <= 0.
    - If overflow is set (including a set on this same edge), bcd <= all digits 4'h9 and ovf <= 1.
    - Next state is DONE.
  - busy=1 for the whole state.
  - start is ignored; bin changes are ignored.
- DONE:
  - done=1 and busy=0 for exactly one cycle (between edges k+W and k+W+1).
  - Next state is IDLE unconditionally; start in DONE is ignored.
- Latency and throughput:
  - done is high in the cycle after edge k+W.
  - The earliest next accept is edge k+W+2, so throughput is one conversion per W+2 cycles.
  - If start is held high continuously, exactly one conversion occurs per W+2 cycles.
- Reset mid-conversion: aborts immediately, with no done pulse. Outputs return to their reset values and the partial result is discarded.
- Arithmetic rules:
  - The add-3 correction is applied before the shift in every iteration.
  - No correction occurs after the final shift.
  - Inputs of all zeros and all ones must produce exact results when 10^DIGITS > 2^W - 1.
- No X propagation: bcd and ovf are always driven from registers.

Test Plan:
1. W=8, DIGITS=3, bin=8'd0, start pulse at edge k -> busy high for 8 cycles; done high in the cycle after edge k+8; bcd=12'h000, ovf=0; done is exactly one cycle.
2. W=8, DIGITS=3, sequential runs:
   - bin=8'd255 -> bcd=12'h255, ovf=0.
   - bin=8'd99 -> bcd=12'h099.
   - bin=8'd128 -> bcd=12'h128.
   - bcd is held stable through the following IDLE cycles.
3. W=4, DIGITS=2, sweep bin=0..15 -> bcd matches the decimal value: 4'd9 -> 8'h09, 4'd10 -> 8'h10, 4'd15 -> 8'h15; every done occurs 4 cycles after its accept.
4. W=8, DIGITS=2:
   - bin=8'd100 -> ovf=1, bcd=8'h99.
   - Next run bin=8'd99 -> ovf=0, bcd=8'h99.
   - bin=8'd255 -> ovf=1.
5. start held high permanently; bin changes every cycle -> each result equals the bin value at its accept edge; accepts occur at k, k+W+2, k+2(W+2); no accept occurs in DONE.
6. rst_n driven low at the 3rd CONV edge of a bin=8'd200 run:
   - Next cycle shows busy=0, done=0, bcd=0, ovf=0, with no done pulse afterwards.
   - A following start with bin=8'd37 yields bcd=12'h037.
